seq_mul_ip: RTL and testbench

- Iterative radix-16 unsigned multiplier IP: the inverse direction of the team's combinational divider IP.
- It rebuilds a dividend from a quotient and divisor, so divider results can be cross-checked in hardware.
- Operands are IP_WIDTH digits of 4 bits each. One multiplier digit is consumed per cycle, MSB-digit first.
- Valid-in / valid-out pulse interface in the same style as the lab IPs.

---
 rtl/seq_mul_ip_pkg.sv | 22 ++
 rtl/seq_mul_ip_if.sv | 22 ++
 rtl/seq_mul_ip_mul_digit_pp.sv | 11 +
 rtl/seq_mul_ip.sv | 79 +++++++
 tb/tb_seq_mul_ip.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/seq_mul_ip_pkg.sv
// Shared types and sizing helpers for the iterative radix-16 multiplier.
// Default-width localparams describe the standard 7-digit build.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int IP_WIDTH_DEF = 7;

    // Digit counter width: clog2 of the digit count, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int OPW  = IP_WIDTH_DEF * 4;
    localparam int PRW  = IP_WIDTH_DEF * 8;
    localparam int CNTW = cnt_width(IP_WIDTH_DEF);

endpackage

// File: rtl/seq_mul_ip_if.sv
// Valid-in / valid-out job interface of the sequential multiplier.
// The master launches jobs; the slave (the multiplier) returns products.
interface seq_mul_if #(
    parameter int IP_WIDTH = 7
);
    logic                    in_valid;
    logic [IP_WIDTH*4-1:0]   IN_Multiplicand;
    logic [IP_WIDTH*4-1:0]   IN_Multiplier;
    logic                    busy;
    logic                    out_valid;
    logic [IP_WIDTH*8-1:0]   OUT_Product;

    modport master (
        output in_valid, IN_Multiplicand, IN_Multiplier,
        input  busy, out_valid, OUT_Product
    );

    modport slave (
        input  in_valid, IN_Multiplicand, IN_Multiplier,
        output busy, out_valid, OUT_Product
    );
endinterface

// File: rtl/seq_mul_ip_mul_digit_pp.sv
// Combinational partial product: full-width operand times one 4-bit digit.
// The result is OPW+4 bits, which holds the largest possible product exactly.
module mul_digit_pp #(
    parameter int OPW = 28
) (
    input  logic [OPW-1:0] a,
    input  logic [3:0]     digit,
    output logic [OPW+3:0] pp
);
    assign pp = {4'h0, a} * {{OPW{1'b0}}, digit};
endmodule

// File: rtl/seq_mul_ip.sv
// Iterative radix-16 unsigned multiplier: one multiplier digit per cycle, MSB digit first.
// Rebuilds a dividend from quotient and divisor; all outputs are registered.
module seq_mul_ip
    import seq_mul_pkg::*;
#(
    parameter int IP_WIDTH = IP_WIDTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    seq_mul_if.slave  bus
);
    localparam int OP_W  = IP_WIDTH * 4;
    localparam int PR_W  = IP_WIDTH * 8;
    localparam int CNT_W = cnt_width(IP_WIDTH);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(IP_WIDTH - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [PR_W-1:0]   acc;
    logic [PR_W-1:0]   acc_next;
    logic [OP_W+3:0]   pp;

    // b_q shifts left each step, so its top nibble is always the current digit.
    mul_digit_pp #(.OPW(OP_W)) u_pp (
        .a     (a_q),
        .digit (b_q[OP_W-1 -: 4]),
        .pp    (pp)
    );

    assign acc_next = {acc[PR_W-5:0], 4'h0} + PR_W'(pp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            acc             <= '0;
            bus.busy        <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.OUT_Product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.out_valid   <= 1'b0;
                    bus.OUT_Product <= '0;
                    if (bus.in_valid) begin
                        a_q      <= bus.IN_Multiplicand;
                        b_q      <= bus.IN_Multiplier;
                        acc      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    b_q <= b_q << 4;
                    cnt <= cnt + CNT_W'(1);
                    // Final digit: publish the completed product directly from the adder.
                    if (cnt == LAST_DIGIT) begin
                        bus.out_valid   <= 1'b1;
                        bus.OUT_Product <= acc_next;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    bus.busy        <= 1'b0;
                    bus.out_valid   <= 1'b0;
                    bus.OUT_Product <= '0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul_ip.sv
// Randomized self-checking bench for seq_mul_ip against a plain-arithmetic product model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seq_mul_ip;
    localparam int W  = 7;
    localparam int OW = W * 4;
    localparam int PW = W * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    seq_mul_if #(.IP_WIDTH(W)) bus ();

    seq_mul_ip #(.IP_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch a job at the current falling edge and watch n_obs cycles after acceptance.
    // With drop set, a competing 7*7 job is offered in every busy cycle.
    task automatic run_job(input logic [OW-1:0] a, input logic [OW-1:0] b,
                           input logic [PW-1:0] exp, input string tag,
                           input int n_obs, input bit drop);
        int lat = 0;
        int pulses = 0;
        bit busy_bad = 1'b0;
        logic [PW-1:0] got = '0;
        bus.in_valid        = 1'b1;
        bus.IN_Multiplicand = a;
        bus.IN_Multiplier   = b;
        @(negedge clk);
        for (int k = 1; k <= n_obs; k++) begin
            if (bus.out_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    got = bus.OUT_Product;
                end
            end
            if (k <= W + 1 && !bus.busy) busy_bad = 1'b1;
            if (k > W + 1 && bus.busy) busy_bad = 1'b1;
            if (drop && k <= W + 1) begin
                bus.in_valid        = 1'b1;
                bus.IN_Multiplicand = OW'(7);
                bus.IN_Multiplier   = OW'(7);
            end else begin
                bus.in_valid        = 1'b0;
                bus.IN_Multiplicand = OW'($urandom);
                bus.IN_Multiplier   = OW'($urandom);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'(W + 1));
        chk({tag, " product"}, 64'(got), 64'(exp));
        chk({tag, " pulses"}, 64'(pulses), 64'd1);
        chk({tag, " busy"}, 64'(busy_bad), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [OW-1:0] q, d, nd, r;
        logic [63:0] full_q, full_d;
        int pulses;

        bus.in_valid        = 1'b0;
        bus.IN_Multiplicand = '0;
        bus.IN_Multiplier   = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset product", 64'(bus.OUT_Product), 64'd0);

        // in_valid together with reset must not start a job.
        bus.in_valid        = 1'b1;
        bus.IN_Multiplicand = OW'(9);
        bus.IN_Multiplier   = OW'(9);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        chk("rst+in_valid busy", 64'(bus.busy), 64'd0);
        @(negedge clk);

        run_job(OW'(28'h0000003), OW'(28'h0000005), PW'(56'h0F), "small", 12, 1'b0);
        run_job(OW'(28'hFFFFFFF), OW'(28'hFFFFFFF), PW'(56'hFFFFFFE0000001), "max", 12, 1'b0);
        run_job(OW'(2), OW'(3), PW'(6), "busy drop", 14, 1'b1);

        // Divider round trip: product of quotient and divisor equals dividend minus remainder.
        for (int i = 0; i < 200; i++) begin
            nd = OW'($urandom);
            d  = OW'($urandom_range(1, 300));
            if (i % 3 == 0) d = OW'($urandom) | OW'(1);
            q  = nd / d;
            r  = nd % d;
            full_q = 64'(q);
            full_d = 64'(d);
            if ((full_q * full_d) != 64'(nd - r)) begin
                n_chk++;
                n_err++;
                $display("FAIL model: q*d 0x%0h, expected 0x%0h", full_q * full_d, nd - r);
            end
            run_job(q, d, PW'(nd - r), $sformatf("rt%0d", i), W + 2, 1'b0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Mid-operation reset drops the in-flight job.
        bus.in_valid        = 1'b1;
        bus.IN_Multiplicand = OW'(5);
        bus.IN_Multiplier   = OW'(9);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 64'(bus.busy), 64'd0);
        chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst product", 64'(bus.OUT_Product), 64'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid) pulses++;
            @(negedge clk);
        end
        chk("midrst stale pulse", 64'(pulses), 64'd0);
        run_job(OW'(28'h10), OW'(28'h10), PW'(56'h100), "after rst", 12, 1'b0);

        // Back-to-back: second job offered in the cycle right after out_valid.
        run_job(OW'(28'h1234567), OW'(28'h89), PW'(64'h1234567 * 64'h89), "b2b first", W + 1, 1'b0);
        run_job(OW'(0), OW'(28'hABCDEF1), PW'(0), "b2b zero", 12, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
